// File: rtl/shift_add32_seq_pkg.sv
// Shared constants and state encoding for the 32-point DCT odd-coefficient
// shift-add sequencer.
package shift_add32_seq_pkg;

    localparam int SA_LANES = 16;
    localparam int SA_WIDTH = 19;
    localparam int SA_ROWS  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add32_seq_if.sv
// Handshake and datapath bundle of the shift-add sequencer. The master modport
// is the sequencer; the slave modport is the surrounding fabric and datapath.
interface shift_add32_seq_if
    import shift_add32_seq_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int ROWS  = SA_ROWS
);
    localparam int DW    = SA_LANES * WIDTH;
    localparam int ROW_W = $clog2(ROWS);

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             dp_rst;
    logic [DW-1:0]    dp_b;
    logic [DW-1:0]    dp_y;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [ROW_W-1:0] out_row;
    logic             out_pass;
    logic             out_last;
    logic             blk_done;

    modport master (
        input  in_valid, in_data, out_ready, dp_y,
        output in_ready, dp_rst, dp_b, out_valid, out_data,
               out_row, out_pass, out_last, blk_done
    );

    modport slave (
        output in_valid, in_data, out_ready, dp_y,
        input  in_ready, dp_rst, dp_b, out_valid, out_data,
               out_row, out_pass, out_last, blk_done
    );

endinterface

// File: rtl/shift_add32_seq_cnt.sv
// Row/pass position of the result currently offered downstream, with the
// last-row flag and the end-of-block pulse.
module shift_add32_seq_cnt
    import shift_add32_seq_pkg::*;
#(
    parameter int ROWS  = SA_ROWS,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             adv,
    output logic [ROW_W-1:0] row,
    output logic             pass,
    output logic             last,
    output logic             done
);

    logic [ROW_W-1:0] row_q, row_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             last_s;

    // Advance on every accepted result; a wrap flips between row and column pass
    always_comb begin
        last_s = (row_q == ROW_W'(ROWS - 1));
        row_d  = row_q;
        pass_d = pass_q;
        if (adv) begin
            if (last_s) begin
                row_d  = '0;
                pass_d = ~pass_q;
            end else begin
                row_d  = row_q + ROW_W'(1);
                pass_d = pass_q;
            end
        end else begin
            row_d  = row_q;
            pass_d = pass_q;
        end
        done_d = adv & last_s & pass_q;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            row_q  <= '0;
            pass_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            pass_q <= pass_d;
            done_q <= done_d;
        end
    end

    assign row  = row_q;
    assign pass = pass_q;
    assign last = last_s;
    assign done = done_q;

endmodule

// File: rtl/shift_add32_seq.sv
// Sequencer for the 16-lane odd shift-add stage: holds one vector on the
// datapath, waits out its register stage and offers the result downstream.
module shift_add32_seq
    import shift_add32_seq_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int ROWS  = SA_ROWS
) (
    input  logic              clk,
    input  logic              rst_b,
    shift_add32_seq_if.master bus
);

    localparam int DW = SA_LANES * WIDTH;

    state_e        state_q, state_d;
    logic [DW-1:0] dp_b_q, dp_b_d;
    logic          rel_q, rel_d;
    logic          dp_rst_q, dp_rst_d;
    logic          en_q, en_d;
    logic          in_ready_s;
    logic          out_valid_s;
    logic          in_hs_s;
    logic          out_hs_s;

    // Release the datapath reset one full cycle after rst_b rises, then enable input
    always_comb begin
        rel_d    = 1'b1;
        dp_rst_d = ~rel_q;
        en_d     = ~dp_rst_q;
    end

    // Next state, handshakes and hold-register load
    always_comb begin
        state_d     = state_q;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_s = en_q;
                if (bus.in_valid && en_q) begin
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                state_d = OUT;
            end
            OUT: begin
                out_valid_s = 1'b1;
                in_ready_s  = bus.out_ready;
                if (bus.out_ready) begin
                    state_d = bus.in_valid ? FILL : IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_hs_s  = bus.in_valid & in_ready_s;
        out_hs_s = out_valid_s & bus.out_ready;
        if (in_hs_s) begin
            dp_b_d = bus.in_data;
        end else begin
            dp_b_d = dp_b_q;
        end
    end

    // State, hold register and reset-release registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            dp_b_q   <= '0;
            rel_q    <= 1'b0;
            dp_rst_q <= 1'b1;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dp_b_q   <= dp_b_d;
            rel_q    <= rel_d;
            dp_rst_q <= dp_rst_d;
            en_q     <= en_d;
        end
    end

    shift_add32_seq_cnt #(
        .ROWS (ROWS)
    ) u_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .adv   (out_hs_s),
        .row   (bus.out_row),
        .pass  (bus.out_pass),
        .last  (bus.out_last),
        .done  (bus.blk_done)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.dp_rst    = dp_rst_q;
    assign bus.dp_b      = dp_b_q;
    assign bus.out_data  = bus.dp_y;

endmodule

// File: tb/tb_shift_add32_seq.sv
// Directed bench for shift_add32_seq with a one-register stand-in datapath
// (lane 0 = 90*b0, other lanes pass through).
module tb_shift_add32_seq;

    localparam int WIDTH = 19;
    localparam int ROWS  = 32;
    localparam int DW    = 16 * WIDTH;

    typedef struct {
        logic [WIDTH-1:0] b0;
        logic [WIDTH-1:0] b1;
        logic [WIDTH-1:0] y1;
        logic [WIDTH-1:0] y2;
        logic [4:0]       row;
    } vec_t;

    logic clk = 1'b0;
    logic rst_b;
    int   n_chk  = 0;
    int   n_fail = 0;

    shift_add32_seq_if #(.WIDTH(WIDTH), .ROWS(ROWS)) bus ();

    shift_add32_seq #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkvec(input logic [WIDTH-1:0] b0, input logic [WIDTH-1:0] b1);
        logic [DW-1:0] v;
        v = '0;
        v[WIDTH-1:0]       = b0;
        v[2*WIDTH-1:WIDTH] = b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] dp_model(input logic [DW-1:0] b);
        logic [DW-1:0]    y;
        logic [WIDTH-1:0] l0;
        y  = b;
        l0 = b[WIDTH-1:0] * 19'd90;
        y[WIDTH-1:0] = l0;
        return y;
    endfunction

    always_ff @(posedge clk) begin
        if (bus.dp_rst) bus.dp_y <= '0;
        else            bus.dp_y <= dp_model(bus.dp_b);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with rst_b low; releases it mid-cycle and checks the dp_rst / in_ready sequence.
    task automatic do_release();
        tick();
        tick();
        #3 rst_b = 1'b1;
        tick();
        chk("rel_e1_dp_rst", bus.dp_rst, 1'b1);
        chk("rel_e1_in_ready", bus.in_ready, 1'b0);
        chk("rel_e1_out_valid", bus.out_valid, 1'b0);
        tick();
        chk("rel_e2_dp_rst", bus.dp_rst, 1'b0);
        chk("rel_e2_in_ready", bus.in_ready, 1'b0);
        chk("rel_e2_out_valid", bus.out_valid, 1'b0);
        tick();
        chk("rel_e3_in_ready", bus.in_ready, 1'b1);
        chk("rel_e3_out_valid", bus.out_valid, 1'b0);
    endtask

    task automatic apply_one(input vec_t v, input logic exp_pass);
        bus.in_data   = mkvec(v.b0, v.b1);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("idle_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("fill_out_valid", bus.out_valid, 1'b0);
        chk("fill_in_ready", bus.in_ready, 1'b0);
        chk_w("fill_dp_b", bus.dp_b, mkvec(v.b0, v.b1));
        tick();
        chk("out_valid", bus.out_valid, 1'b1);
        chk("out_y1", bus.out_data[WIDTH-1:0], v.y1);
        chk("out_y2", bus.out_data[2*WIDTH-1:WIDTH], v.y2);
        chk("out_row", bus.out_row, v.row);
        chk("out_pass", bus.out_pass, exp_pass);
        chk("out_last", bus.out_last, 1'b0);
        tick();
        chk("after_out_valid", bus.out_valid, 1'b0);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        logic [DW-1:0] va, vb;
        int nin, nout, last_hs, pulses;
        bit done_exp;

        tbl[0] = '{b0: 19'd1,       b1: 19'd0,       y1: 19'd90,      y2: 19'd0,       row: 5'd0};
        tbl[1] = '{b0: 19'd2,       b1: 19'd7,       y1: 19'd180,     y2: 19'd7,       row: 5'd1};
        tbl[2] = '{b0: 19'd0,       b1: 19'h7FFFF,   y1: 19'd0,       y2: 19'h7FFFF,   row: 5'd2};
        tbl[3] = '{b0: 19'd100,     b1: 19'd3,       y1: 19'd9000,    y2: 19'd3,       row: 5'd3};
        tbl[4] = '{b0: 19'h7FFFF,   b1: 19'd1,       y1: 19'h7FFA6,   y2: 19'd1,       row: 5'd4};
        tbl[5] = '{b0: 19'd5000,    b1: 19'd12345,   y1: 19'd450000,  y2: 19'd12345,   row: 5'd5};

        rst_b         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        chk("reset_in_ready", bus.in_ready, 1'b0);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk_w("reset_dp_b", bus.dp_b, '0);
        chk("reset_row", bus.out_row, 5'd0);
        chk("reset_pass", bus.out_pass, 1'b0);
        chk("reset_blk_done", bus.blk_done, 1'b0);
        chk("reset_dp_rst", bus.dp_rst, 1'b1);
        do_release();

        for (int i = 0; i < 6; i++) apply_one(tbl[i], 1'b0);

        // Backpressure: vector A stalled 5 cycles with B waiting on the input.
        va = mkvec(19'd3, 19'd0);
        vb = mkvec(19'd4, 19'd0);
        bus.in_data   = va;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        tick();
        bus.in_data   = vb;
        bus.out_ready = 1'b0;
        #1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", bus.out_valid, 1'b1);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk_w("bp_dp_b", bus.dp_b, va);
            chk("bp_y1", bus.out_data[WIDTH-1:0], 19'd270);
            chk("bp_row", bus.out_row, 5'd6);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("bp_b_out_valid", bus.out_valid, 1'b0);
        chk_w("bp_b_dp_b", bus.dp_b, vb);
        tick();
        chk("bp_b_valid", bus.out_valid, 1'b1);
        chk("bp_b_y1", bus.out_data[WIDTH-1:0], 19'd360);
        chk("bp_b_row", bus.out_row, 5'd7);
        tick();

        v = '{b0: 19'd8, b1: 19'd0, y1: 19'd720, y2: 19'd0, row: 5'd8};
        apply_one(v, 1'b0);
        v = '{b0: 19'd9, b1: 19'd0, y1: 19'd810, y2: 19'd0, row: 5'd9};
        apply_one(v, 1'b0);

        // Reset while the eleventh vector sits in FILL.
        bus.in_data  = mkvec(19'd11, 19'd0);
        bus.in_valid = 1'b1;
        #1;
        tick();
        bus.in_valid = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_in_ready", bus.in_ready, 1'b0);
        chk_w("midrst_dp_b", bus.dp_b, '0);
        chk("midrst_row", bus.out_row, 5'd0);
        chk("midrst_dp_rst", bus.dp_rst, 1'b1);
        do_release();
        v = '{b0: 19'd6, b1: 19'd0, y1: 19'd540, y2: 19'd0, row: 5'd0};
        apply_one(v, 1'b0);

        // Streaming 64 vectors from a fresh reset.
        #2 rst_b = 1'b0;
        #1;
        chk("prestream_blk_done", bus.blk_done, 1'b0);
        do_release();
        nin = 0; nout = 0; last_hs = -1; pulses = 0; done_exp = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = mkvec(19'd1, 19'd0);
        #1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (nout == 64 && cyc > last_hs + 3) break;
            chk("stream_blk_done", bus.blk_done, done_exp);
            if (bus.blk_done) pulses++;
            done_exp = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                logic [WIDTH-1:0] ey;
                ey = WIDTH'(90 * (nout + 1));
                chk("stream_row", bus.out_row, nout % 32);
                chk("stream_pass", bus.out_pass, nout / 32);
                chk("stream_last", bus.out_last, (nout % 32) == 31);
                chk("stream_y1", bus.out_data[WIDTH-1:0], ey);
                if (last_hs >= 0) chk("stream_gap", cyc - last_hs, 2);
                last_hs = cyc;
                nout++;
                if (nout == 64) done_exp = 1'b1;
            end
            if (bus.in_valid && bus.in_ready) nin++;
            tick();
            if (nin >= 64) bus.in_valid = 1'b0;
            else           bus.in_data  = mkvec(WIDTH'(nin + 1), 19'd0);
            #1;
        end
        chk("stream_outputs", nout, 64);
        chk("stream_done_pulses", pulses, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
